// File: rtl/swim_byte_tx_if.sv
// Byte-side handshake, SWIM pin and ACK result signals of the SWIM byte transmitter.
// The master side feeds bytes and the pin level; the slave side is the transmitter.
interface swim_byte_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       swim_in;
    logic       swim_drive_low;
    logic       busy;
    logic       ack_valid;
    logic       ack_ok;
    logic       ack_timeout;

    modport master (
        output in_data,
        output in_valid,
        output swim_in,
        input  in_ready,
        input  swim_drive_low,
        input  busy,
        input  ack_valid,
        input  ack_ok,
        input  ack_timeout
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  swim_in,
        output in_ready,
        output swim_drive_low,
        output busy,
        output ack_valid,
        output ack_ok,
        output ack_timeout
    );
endinterface

// File: rtl/swim_byte_tx.sv
// SWIM byte transmitter: frames one byte as {start, d7..d0, parity}, sends each
// bit as a long/short low pulse on the open-drain SWIM line, then listens for
// the target's ACK/NACK pulse (or times out) and reports the result.
module swim_byte_tx #(
    parameter int unsigned TICK_DIV    = 6,
    parameter int unsigned BIT_TICKS   = 22,
    parameter int unsigned SHORT_TICKS = 2,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    swim_byte_tx_if.slave bus
);

    localparam int DIV_W  = $clog2(TICK_DIV + 1);
    localparam int TICK_W = $clog2(BIT_TICKS + 1);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] SAMPLE_AT  = TICK_W'(BIT_TICKS / 2 - 1);
    localparam logic [TICK_W-1:0] LOW_SHORT  = TICK_W'(SHORT_TICKS);
    localparam logic [TICK_W-1:0] LOW_LONG   = TICK_W'(BIT_TICKS - SHORT_TICKS);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [3:0]        LAST_BIT   = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT,
        ST_ACK_WAIT,
        ST_ACK_MEAS,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic [9:0]          frame_q, frame_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                meas_ok_q, meas_ok_d;
    logic                ack_ok_q, ack_ok_d;
    logic                ack_timeout_q, ack_timeout_d;
    logic                ready_en_q, ready_en_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                sync_prev_q, sync_prev_d;

    logic                tick;
    logic                transfer;
    logic                ack_fall;
    logic                cur_bit;
    logic                in_ready_c;
    logic                drive_low_c;

    // Pin synchronizer and edge history; the previous synchronized level lets
    // the ACK wait spot a clean high-to-low transition.
    always_comb begin
        sync1_d     = bus.swim_in;
        sync2_d     = sync1_q;
        sync_prev_d = sync2_q;
        ack_fall    = sync_prev_q & ~sync2_q;
    end

    // Handshake and bit-shape decode; the current bit is always frame_q[9]
    // because the frame shifts left as each bit completes.
    always_comb begin
        ready_en_d  = 1'b1;
        in_ready_c  = (state_q == ST_IDLE) && ready_en_q;
        transfer    = in_ready_c && bus.in_valid;
        cur_bit     = frame_q[9];
        drive_low_c = 1'b0;
        if (state_q == ST_BIT) begin
            drive_low_c = cur_bit ? (tick_cnt_q < LOW_SHORT) : (tick_cnt_q < LOW_LONG);
        end
    end

    // Tick divider: free-running, but restarted on acceptance so the frame's
    // tick grid is anchored to the start bit.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + 1'b1;
        if (transfer || tick) begin
            div_cnt_d = '0;
        end
    end

    // Frame sequencer: bit timing, ACK edge wait with timeout, ACK sampling.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_idx_d     = bit_idx_q;
        frame_d       = frame_q;
        to_cnt_d      = to_cnt_q;
        meas_ok_d     = meas_ok_q;
        ack_ok_d      = ack_ok_q;
        ack_timeout_d = ack_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d    = ST_BIT;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    frame_d    = {1'b0, bus.in_data, ^bus.in_data};
                end
            end

            ST_BIT: begin
                if (tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        frame_d    = {frame_q[8:0], 1'b0};
                        if (bit_idx_q == LAST_BIT) begin
                            state_d   = ST_ACK_WAIT;
                            bit_idx_d = '0;
                            to_cnt_d  = '0;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_ACK_WAIT: begin
                if (ack_fall) begin
                    state_d    = ST_ACK_MEAS;
                    tick_cnt_d = '0;
                    meas_ok_d  = 1'b0;
                end else if (tick) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d       = ST_DONE;
                        ack_ok_d      = 1'b0;
                        ack_timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end

            ST_ACK_MEAS: begin
                if (tick) begin
                    if (tick_cnt_q == SAMPLE_AT) begin
                        meas_ok_d = sync2_q;
                    end
                    if (tick_cnt_q == BIT_LAST) begin
                        state_d       = ST_DONE;
                        tick_cnt_d    = '0;
                        ack_ok_d      = meas_ok_q;
                        ack_timeout_d = 1'b0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset parks everything idle with the
    // synchronizer reading the released (high) line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            bit_idx_q     <= '0;
            frame_q       <= '0;
            to_cnt_q      <= '0;
            meas_ok_q     <= 1'b0;
            ack_ok_q      <= 1'b0;
            ack_timeout_q <= 1'b0;
            ready_en_q    <= 1'b0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            sync_prev_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            frame_q       <= frame_d;
            to_cnt_q      <= to_cnt_d;
            meas_ok_q     <= meas_ok_d;
            ack_ok_q      <= ack_ok_d;
            ack_timeout_q <= ack_timeout_d;
            ready_en_q    <= ready_en_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync_prev_q   <= sync_prev_d;
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.swim_drive_low = drive_low_c;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.ack_valid      = (state_q == ST_DONE);
    assign bus.ack_ok         = ack_ok_q;
    assign bus.ack_timeout    = ack_timeout_q;

endmodule

// File: tb/tb_swim_byte_tx.sv
// Bench for swim_byte_tx: a stimulus process queues expected frames and ACK
// results, a monitor decodes the SWIM line and ACK pulses and compares them
// against the queues, and a target model answers each frame with ACK, NACK
// or silence.
`timescale 1ns/1ps
module tb_swim_byte_tx;

    localparam int TICK_DIV    = 6;
    localparam int BIT_TICKS   = 22;
    localparam int SHORT_TICKS = 2;
    localparam int ACK_TIMEOUT = 64;

    localparam int BIT_CLK     = TICK_DIV * BIT_TICKS;
    localparam int LONG_CLK    = TICK_DIV * (BIT_TICKS - SHORT_TICKS);
    localparam int SHORT_CLK   = TICK_DIV * SHORT_TICKS;
    localparam int FRAME_CLK   = 10 * BIT_CLK;
    localparam int TIMEOUT_CLK = ACK_TIMEOUT * TICK_DIV;

    typedef struct packed {
        logic ok;
        logic to;
        logic timed;
    } ack_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic target_low = 1'b0;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int acks_seen = 0;

    logic [9:0] frame_q[$];
    ack_exp_t   ack_q[$];
    int         resp_q[$];

    event frame_done;

    swim_byte_tx_if bus();

    assign bus.swim_in = ~(bus.swim_drive_low | target_low);

    swim_byte_tx #(
        .TICK_DIV    (TICK_DIV),
        .BIT_TICKS   (BIT_TICKS),
        .SHORT_TICKS (SHORT_TICKS),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic logic [9:0] frameOf(input logic [7:0] b);
        return {1'b0, b, ^b};
    endfunction

    function automatic ack_exp_t ackOf(input int mode);
        ack_exp_t e;
        e.ok    = (mode == 0);
        e.to    = (mode == 2);
        e.timed = (mode == 2);
        return e;
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input int mode, input bit hold, input bit expect_it);
        int waitc;
        waitc = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waitc < 4000) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_wait", 32'(0), 32'(1));
            bus.in_valid = 1'b0;
            return;
        end
        if (expect_it) begin
            frame_q.push_back(frameOf(b));
            ack_q.push_back(ackOf(mode));
            resp_q.push_back(mode);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
    endtask

    // Monitor: decode the driven line bit by bit and check ACK results.
    initial begin : monitor
        logic d;
        logic prev_drive;
        logic bit_open;
        logic expect_rise;
        logic shape_err;
        logic ready_busy;
        logic post_ack;
        logic last_ok;
        logic last_to;
        logic [9:0] dec;
        int low_len;
        int high_len;
        int nbits;
        int frame_start;
        logic [9:0] exp_frame;
        ack_exp_t e;
        prev_drive = 1'b0; bit_open = 1'b0; expect_rise = 1'b0; shape_err = 1'b0;
        ready_busy = 1'b0; post_ack = 1'b0; last_ok = 1'b0; last_to = 1'b0;
        dec = '0; low_len = 0; high_len = 0; nbits = 0; frame_start = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                prev_drive = 1'b0; bit_open = 1'b0; expect_rise = 1'b0; shape_err = 1'b0;
                ready_busy = 1'b0; post_ack = 1'b0; last_ok = 1'b0; last_to = 1'b0;
                nbits = 0;
            end else begin
                d = bus.swim_drive_low;
                if (post_ack) begin
                    checkOutput("in_ready_after_ack", 32'(bus.in_ready), 32'(1));
                    checkOutput("busy_after_ack", 32'(bus.busy), 32'(0));
                    post_ack = 1'b0;
                end
                if (bus.busy && bus.in_ready) ready_busy = 1'b1;
                if (expect_rise && !d) shape_err = 1'b1;
                expect_rise = 1'b0;
                if (d) begin
                    if (!prev_drive) begin
                        if (bit_open) shape_err = 1'b1;
                        if (nbits == 0) begin
                            frame_start = cycle;
                            checkOutput("ack_ok_hold", 32'(bus.ack_ok), 32'(last_ok));
                            checkOutput("ack_timeout_hold", 32'(bus.ack_timeout), 32'(last_to));
                        end
                        bit_open = 1'b1;
                        low_len  = 1;
                        high_len = 0;
                    end else if (bit_open) begin
                        low_len++;
                        if (low_len > BIT_CLK) shape_err = 1'b1;
                    end else begin
                        shape_err = 1'b1;
                    end
                end else if (bit_open) begin
                    high_len++;
                    if (low_len + high_len == BIT_CLK) begin
                        bit_open = 1'b0;
                        if (low_len == LONG_CLK) dec = {dec[8:0], 1'b0};
                        else if (low_len == SHORT_CLK) dec = {dec[8:0], 1'b1};
                        else shape_err = 1'b1;
                        nbits++;
                        if (nbits < 10) begin
                            expect_rise = 1'b1;
                        end else begin
                            nbits = 0;
                            if (frame_q.size() == 0) begin
                                checkOutput("frame_unexpected", 32'(1), 32'(0));
                            end else begin
                                exp_frame = frame_q.pop_front();
                                checkOutput("frame_bits", 32'(dec), 32'(exp_frame));
                                checkOutput("frame_shape", 32'(shape_err), 32'(0));
                                checkOutput("frame_len", 32'(cycle - frame_start + 1), 32'(FRAME_CLK));
                            end
                            shape_err = 1'b0;
                            -> frame_done;
                        end
                    end
                end
                prev_drive = d;
                if (bus.ack_valid) begin
                    acks_seen++;
                    if (ack_q.size() == 0) begin
                        checkOutput("ack_unexpected", 32'(1), 32'(0));
                    end else begin
                        e = ack_q.pop_front();
                        checkOutput("ack_ok", 32'(bus.ack_ok), 32'(e.ok));
                        checkOutput("ack_timeout", 32'(bus.ack_timeout), 32'(e.to));
                        if (e.timed) begin
                            checkOutput("timeout_latency", 32'(cycle - frame_start), 32'(FRAME_CLK + TIMEOUT_CLK));
                        end
                    end
                    checkOutput("in_ready_during_frame", 32'(ready_busy), 32'(0));
                    checkOutput("in_ready_at_ack", 32'(bus.in_ready), 32'(0));
                    last_ok    = bus.ack_ok;
                    last_to    = bus.ack_timeout;
                    ready_busy = 1'b0;
                    post_ack   = 1'b1;
                end
            end
        end
    end

    // Target model: 0 = ACK (2-tick low), 1 = NACK (20-tick low), 2 = silent.
    initial begin : responder
        int mode;
        forever begin
            @(frame_done);
            mode = (resp_q.size() != 0) ? resp_q.pop_front() : 2;
            repeat (8) @(negedge clk);
            if (mode == 0) begin
                target_low = 1'b1;
                repeat (2 * TICK_DIV) @(negedge clk);
                target_low = 1'b0;
            end else if (mode == 1) begin
                target_low = 1'b1;
                repeat (20 * TICK_DIV) @(negedge clk);
                target_low = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #(90000 * 10);
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: simulation did not finish, got no end, wanted end");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stimulus
        int acks_before;
        int waitc;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(0));
        checkOutput("rst_drive_low", 32'(bus.swim_drive_low), 32'(0));
        checkOutput("rst_busy", 32'(bus.busy), 32'(0));
        checkOutput("rst_ack_valid", 32'(bus.ack_valid), 32'(0));
        checkOutput("rst_ack_ok", 32'(bus.ack_ok), 32'(0));
        checkOutput("rst_ack_timeout", 32'(bus.ack_timeout), 32'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'(1));

        applyStimulus(8'h00, 0, 1'b0, 1'b1);
        applyStimulus(8'h80, 0, 1'b0, 1'b1);
        applyStimulus(8'hA5, 1, 1'b0, 1'b1);
        applyStimulus(8'h3C, 2, 1'b0, 1'b1);
        applyStimulus(8'h11, 0, 1'b1, 1'b1);
        applyStimulus(8'h22, 1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), 1'b1);
        end

        applyStimulus(8'h5A, 0, 1'b0, 1'b0);
        repeat (4 * BIT_CLK + 6) @(negedge clk);
        checkOutput("drive_before_reset", 32'(bus.swim_drive_low), 32'(1));
        acks_before = acks_seen;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("drive_on_reset", 32'(bus.swim_drive_low), 32'(0));
        checkOutput("busy_on_reset", 32'(bus.busy), 32'(0));
        checkOutput("in_ready_on_reset", 32'(bus.in_ready), 32'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("no_ack_after_reset", 32'(acks_seen), 32'(acks_before));

        applyStimulus(8'hC3, 0, 1'b0, 1'b1);

        waitc = 0;
        while ((ack_q.size() != 0 || frame_q.size() != 0) && waitc < 5000) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("drain_pending", 32'(ack_q.size() + frame_q.size()), 32'(0));
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
